shift_sequencer: RTL and testbench

- Multi-cycle sequencer that sits directly upstream of the 16-bit combinational shifter and also consumes its output.
- Accepts a shift command (operand, direction, 6-bit total amount) over a valid/ready handshake.
- Drives the shifter iteratively with at most 15 positions per cycle and feeds each partial result back into an operand register.
- Returns the final result over a valid/ready handshake, extending the datapath's shift range from 0..15 to 0..63.

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shifts.sv | 19 +
 rtl/shift_sequencer.sv | 93 +++++++++
 tb/tb_shift_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative shift sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int   STEP_MAX  = 15;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shifts.sv
// 16-bit combinational logical shifter, 0..15 positions, zero fill.
module shifts
    import shift_seq_pkg::*;
(
    input  logic [15:0] A,
    input  logic        ir,
    input  logic [3:0]  amt,
    output logic [15:0] Y
);

    always_comb begin
        if (ir == DIR_LEFT) begin
            Y = A << amt;
        end else begin
            Y = A >> amt;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Extends the 16-bit shifter to 0..63 positions by chaining up to STEP_MAX
// positions per cycle through an operand feedback register.
module shift_sequencer #(
    parameter int DATA_W   = 16,
    parameter int AMT_W    = 6,
    parameter int STEP_MAX = shift_seq_pkg::STEP_MAX,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    import shift_seq_pkg::*;

    localparam int STEP_W = $clog2(STEP_MAX + 1);

    seq_state_t        state;
    logic [DATA_W-1:0] opnd;
    logic [AMT_W-1:0]  rem;
    logic [AMT_W-1:0]  rem_next;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic [DATA_W-1:0] y;

    // step never exceeds rem, so rem_next cannot underflow
    always_comb begin
        step     = (rem > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem[STEP_W-1:0];
        rem_next = rem - AMT_W'(step);
    end

    shifts u_shifts (
        .A   (opnd),
        .ir  (dir),
        .amt (step),
        .Y   (y)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            opnd      <= '0;
            rem       <= '0;
            dir       <= DIR_RIGHT;
            out_data  <= '0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd  <= in_data;
                        rem   <= in_amt;
                        dir   <= in_dir;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // rem==0 on entry still takes one zero-amount pass
                    opnd <= y;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        out_data  <= y;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_dir;
    logic [5:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  op_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, measure edges until out_valid, check result, then consume it.
    task automatic run_cmd(input string tag, input logic [15:0] d, input logic dr,
                           input logic [5:0] amt, input logic [15:0] exp, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_dir   = dr;
        in_amt   = amt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        in_dir   = ~dr;
        in_amt   = ~amt;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
    endtask

    // Lightweight zero-amount op used to walk op_count around its wrap.
    task automatic quick_op();
        int guard;
        in_data  = 16'h1234;
        in_dir   = 1'b0;
        in_amt   = 6'd0;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        in_dir    = 1'b1;
        in_amt    = 6'd5;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0000);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle_busy", 32'(busy), 32'd0);

        run_cmd("left1",    16'h8001, 1'b1, 6'd1,  16'h0002, 1);
        run_cmd("right15",  16'h8000, 1'b0, 6'd15, 16'h0001, 1);
        run_cmd("right17",  16'hF000, 1'b0, 6'd17, 16'h0000, 2);
        run_cmd("zero_amt", 16'hA5A5, 1'b1, 6'd0,  16'hA5A5, 1);
        run_cmd("left15",   16'h0001, 1'b1, 6'd15, 16'h8000, 1);
        run_cmd("left4",    16'h00FF, 1'b1, 6'd4,  16'h0FF0, 1);
        run_cmd("right8",   16'hABCD, 1'b0, 6'd8,  16'h00AB, 1);
        run_cmd("left16",   16'hFFFF, 1'b1, 6'd16, 16'h0000, 2);
        run_cmd("right30",  16'hFFFF, 1'b0, 6'd30, 16'h0000, 2);
        run_cmd("left31",   16'h0001, 1'b1, 6'd31, 16'h0000, 3);

        // Backpressure: 63 positions takes 5 SHIFT cycles, then hold out_ready low.
        begin
            int lat;
            in_data  = 16'hFFFF;
            in_dir   = 1'b1;
            in_amt   = 6'd63;
            in_valid = 1'b1;
            tick();
            in_data = 16'h1111;
            in_amt  = 6'd1;
            lat = 0;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("bp_lat", 32'(lat), 32'd5);
            for (int i = 0; i < 10; i++) begin
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_data", 32'(out_data), 32'h0000);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_busy", 32'(busy), 32'd1);
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_cnt = exp_cnt + 8'd1;
            check("bp_release_valid", 32'(out_valid), 32'd0);
            check("bp_release_busy", 32'(busy), 32'd0);
            check("bp_release_ready", 32'(in_ready), 32'd1);
            check("bp_cnt", 32'(op_count), 32'(exp_cnt));
            tick();
            check("bp_no_accept", 32'(busy), 32'd0);
        end

        // out_ready already high when DONE is entered.
        begin
            in_data   = 16'h0F0F;
            in_dir    = 1'b1;
            in_amt    = 6'd3;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            check("early_rdy_valid", 32'(out_valid), 32'd1);
            check("early_rdy_data", 32'(out_data), 32'h7878);
            tick();
            out_ready = 1'b0;
            exp_cnt = exp_cnt + 8'd1;
            check("early_rdy_done", 32'(busy), 32'd0);
            check("early_rdy_cnt", 32'(op_count), 32'(exp_cnt));
        end

        // Reset in the second SHIFT cycle of a 3-step command.
        begin
            in_data  = 16'h00F0;
            in_dir   = 1'b0;
            in_amt   = 6'd45;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            check("midrst_busy_before", 32'(busy), 32'd1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            exp_cnt = 8'd0;
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_cnt", 32'(op_count), 32'd0);
            for (int i = 0; i < 6; i++) begin
                check("midrst_no_valid", 32'(out_valid), 32'd0);
                tick();
            end
            check("midrst_cnt_after", 32'(op_count), 32'd0);
        end

        // Walk op_count through its wrap.
        for (int i = 0; i < 255; i++) quick_op();
        check("cnt_ff", 32'(op_count), 32'h00FF);
        quick_op();
        check("cnt_wrap", 32'(op_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
